// File: rtl/stage_seq_pkg.sv
// Shared types and helpers for the processor stage sequencer.
package stage_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } seq_state_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_BUSERR  = 2'b10;

  localparam int MAX_STAGES = 32;

  // One-hot of a 1-based stage number; out-of-range stages give zero.
  function automatic logic [MAX_STAGES-1:0] stage_onehot(input int stage, input int num_stages);
    logic [MAX_STAGES-1:0] oh;
    oh = '0;
    if (stage >= 1 && stage <= num_stages && stage <= MAX_STAGES)
      oh = {{(MAX_STAGES-1){1'b0}}, 1'b1} << (stage - 1);
    return oh;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Cycle counter for an outstanding memory access; flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [TW-1:0] count_q, count_d;

  assign expire = (count_q == TW'(MEM_TIMEOUT - 1));

  // Saturates at the expiry value so a stalled count never wraps back to zero.
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable && !expire)
      count_d = count_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/stage_sequencer.sv
// Run/halt/single-step stage sequencer with MFC handshake, timeout and bus-error fault.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int STAGE_W     = 3,
  parameter int MEM_STAGE   = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Run,
  input  logic                  Halt_Req,
  input  logic                  Mode_Step,
  input  logic                  Step,
  input  logic                  Mem_Op,
  input  logic                  MEM_MFC,
  input  logic                  MEM_ERROR,
  output logic [STAGE_W-1:0]    Stage,
  output logic [NUM_STAGES-1:0] Stage_Strobe,
  output logic                  Mem_Req,
  output logic                  Busy,
  output logic                  Fault,
  output logic [1:0]            Fault_Code,
  output logic [CNT_W-1:0]      Cycle_Count,
  output logic [CNT_W-1:0]      Instr_Count
);

  seq_state_e               state_q, state_d;
  logic [STAGE_W-1:0]       stage_q, stage_d;
  logic [1:0]               code_q, code_d;
  logic [CNT_W-1:0]         cycle_q, cycle_d;
  logic [CNT_W-1:0]         instr_q, instr_d;
  logic                     step_prev_q, step_prev_d;

  logic                     step_edge, go, advance, last_stage, busy;
  logic                     tmr_clr, tmr_en, tmr_expire;
  logic [MAX_STAGES-1:0]    strobe_full;
  logic                     unused_strobe_bits;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  assign busy = (state_q == RUN) || (state_q == MEM_WAIT);

  always_comb begin
    step_edge   = Step & ~step_prev_q;
    go          = Mode_Step ? step_edge : 1'b1;
    last_stage  = (stage_q == STAGE_W'(NUM_STAGES));
    step_prev_d = Step;
    state_d     = state_q;
    stage_d     = stage_q;
    code_d      = code_q;
    instr_d     = instr_q;
    cycle_d     = busy ? cycle_q + CNT_W'(1) : cycle_q;
    advance     = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!Halt_Req && Run) begin
          state_d = RUN;
          stage_d = STAGE_W'(1);
        end
      end
      RUN: begin
        if (go) begin
          if (stage_q == STAGE_W'(1) || (stage_q == STAGE_W'(MEM_STAGE) && Mem_Op)) begin
            state_d = MEM_WAIT;
            tmr_clr = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        // Step is deliberately not consulted here: an issued access runs to completion.
        tmr_en = 1'b1;
        if (MEM_ERROR) begin
          state_d = FAULT;
          code_d  = FC_BUSERR;
        end else if (MEM_MFC) begin
          advance = 1'b1;
        end else if (tmr_expire) begin
          state_d = FAULT;
          code_d  = FC_TIMEOUT;
        end
      end
      default: ;
    endcase

    if (advance) begin
      if (last_stage) begin
        stage_d = STAGE_W'(1);
        instr_d = instr_q + CNT_W'(1);
        state_d = Halt_Req ? IDLE : RUN;
      end else begin
        stage_d = stage_q + STAGE_W'(1);
        state_d = RUN;
      end
    end

    strobe_full = stage_onehot(int'(stage_q), NUM_STAGES);
  end

  assign unused_strobe_bits = ^strobe_full;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      stage_q     <= STAGE_W'(1);
      code_q      <= FC_NONE;
      cycle_q     <= '0;
      instr_q     <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      code_q      <= code_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign Stage        = stage_q;
  assign Stage_Strobe = advance ? strobe_full[NUM_STAGES-1:0] : '0;
  assign Mem_Req      = (state_q == MEM_WAIT);
  assign Busy         = busy;
  assign Fault        = (state_q == FAULT);
  assign Fault_Code   = code_q;
  assign Cycle_Count  = cycle_q;
  assign Instr_Count  = instr_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed table-driven bench for stage_sequencer plus multi-cycle corner sequences.
module tb_stage_sequencer;

  logic        Clock, Reset_n;
  logic        Run, Halt_Req, Mode_Step, Step, Mem_Op, MEM_MFC, MEM_ERROR;
  logic [2:0]  Stage;
  logic [4:0]  Stage_Strobe;
  logic        Mem_Req, Busy, Fault;
  logic [1:0]  Fault_Code;
  logic [31:0] Cycle_Count, Instr_Count;

  int checks   = 0;
  int failures = 0;

  // in  = {Run, Halt_Req, Mode_Step, Step, Mem_Op, MEM_MFC, MEM_ERROR}
  // ctl = {Mem_Req, Busy}
  typedef struct {
    logic [6:0] in;
    logic [2:0] stage;
    logic [4:0] strobe;
    logic [1:0] ctl;
  } vec_t;

  vec_t vecs[$];

  stage_sequencer #(
    .NUM_STAGES(5), .STAGE_W(3), .MEM_STAGE(4), .MEM_TIMEOUT(16), .CNT_W(32)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Halt_Req(Halt_Req),
    .Mode_Step(Mode_Step), .Step(Step), .Mem_Op(Mem_Op), .MEM_MFC(MEM_MFC),
    .MEM_ERROR(MEM_ERROR), .Stage(Stage), .Stage_Strobe(Stage_Strobe),
    .Mem_Req(Mem_Req), .Busy(Busy), .Fault(Fault), .Fault_Code(Fault_Code),
    .Cycle_Count(Cycle_Count), .Instr_Count(Instr_Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    {Run, Halt_Req, Mode_Step, Step, Mem_Op, MEM_MFC, MEM_ERROR} = in;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    drive(7'b0);
    Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic add(input logic [6:0] in, input logic [2:0] st, input logic [4:0] sb,
                     input logic [1:0] ctl);
    vec_t v;
    v.in = in; v.stage = st; v.strobe = sb; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      drive(vecs[i].in);
      #1;
      check($sformatf("%s[%0d].stage", tag, i), 32'(Stage), 32'(vecs[i].stage));
      check($sformatf("%s[%0d].strobe", tag, i), 32'(Stage_Strobe), 32'(vecs[i].strobe));
      check($sformatf("%s[%0d].mem_req", tag, i), 32'(Mem_Req), 32'(vecs[i].ctl[1]));
      check($sformatf("%s[%0d].busy", tag, i), 32'(Busy), 32'(vecs[i].ctl[0]));
      @(posedge Clock);
      #1;
    end
    vecs.delete();
  endtask

  initial begin
    drive(7'b0);
    Reset_n = 1'b1;
    #2;
    do_reset();

    check("rst.stage", 32'(Stage), 32'd1);
    check("rst.strobe", 32'(Stage_Strobe), 32'd0);
    check("rst.mem_req", 32'(Mem_Req), 32'd0);
    check("rst.busy", 32'(Busy), 32'd0);
    check("rst.fault", 32'(Fault), 32'd0);
    check("rst.code", 32'(Fault_Code), 32'd0);
    check("rst.cycles", Cycle_Count, 32'd0);
    check("rst.instrs", Instr_Count, 32'd0);

    // Free run, no data access, MFC held high: 1,1,2,3,4,5 per instruction.
    add(7'b1000010, 3'd1, 5'b00000, 2'b00);
    for (int n = 0; n < 3; n++) begin
      add(7'b1000010, 3'd1, 5'b00000, 2'b01);
      add(7'b1000010, 3'd1, 5'b00001, 2'b11);
      add(7'b1000010, 3'd2, 5'b00010, 2'b01);
      add(7'b1000010, 3'd3, 5'b00100, 2'b01);
      add(7'b1000010, 3'd4, 5'b01000, 2'b01);
      add(7'b1000010, 3'd5, 5'b10000, 2'b01);
    end
    run_vecs("free");
    check("free.instrs", Instr_Count, 32'd3);
    check("free.cycles", Cycle_Count, 32'd18);

    // Data access with late MFC in stage 4, halt raised in stage 2.
    do_reset();
    add(7'b1000010, 3'd1, 5'b00000, 2'b00);
    add(7'b1000010, 3'd1, 5'b00000, 2'b01);
    add(7'b1000010, 3'd1, 5'b00001, 2'b11);
    add(7'b1100010, 3'd2, 5'b00010, 2'b01);
    add(7'b1100010, 3'd3, 5'b00100, 2'b01);
    add(7'b1100100, 3'd4, 5'b00000, 2'b01);
    add(7'b1100100, 3'd4, 5'b00000, 2'b11);
    add(7'b1100100, 3'd4, 5'b00000, 2'b11);
    add(7'b1100110, 3'd4, 5'b01000, 2'b11);
    add(7'b1100000, 3'd5, 5'b10000, 2'b01);
    add(7'b1100000, 3'd1, 5'b00000, 2'b00);
    add(7'b0000000, 3'd1, 5'b00000, 2'b00);
    run_vecs("memop_halt");
    check("memop_halt.instrs", Instr_Count, 32'd1);
    check("memop_halt.cycles", Cycle_Count, 32'd9);

    // Single-step: a held Step advances once; fetch wait completes without Step.
    do_reset();
    add(7'b1010010, 3'd1, 5'b00000, 2'b00);
    add(7'b1010010, 3'd1, 5'b00000, 2'b01);
    add(7'b1011010, 3'd1, 5'b00000, 2'b01);
    add(7'b1011010, 3'd1, 5'b00001, 2'b11);
    add(7'b1011010, 3'd2, 5'b00000, 2'b01);
    add(7'b1010010, 3'd2, 5'b00000, 2'b01);
    add(7'b1011010, 3'd2, 5'b00010, 2'b01);
    add(7'b1010010, 3'd3, 5'b00000, 2'b01);
    add(7'b1011010, 3'd3, 5'b00100, 2'b01);
    add(7'b1010010, 3'd4, 5'b00000, 2'b01);
    add(7'b1011010, 3'd4, 5'b01000, 2'b01);
    add(7'b1010010, 3'd5, 5'b00000, 2'b01);
    add(7'b1011010, 3'd5, 5'b10000, 2'b01);
    add(7'b1010010, 3'd1, 5'b00000, 2'b01);
    run_vecs("step");
    check("step.instrs", Instr_Count, 32'd1);
    check("step.cycles", Cycle_Count, 32'd13);

    // Fetch MFC never arrives: fault 16 clocks after Mem_Req rises.
    do_reset();
    drive(7'b1000000);
    tick();
    tick();
    check("tmo.mem_req_rise", 32'(Mem_Req), 32'd1);
    for (int k = 1; k < 16; k++) begin
      tick();
      check($sformatf("tmo.wait%0d.fault", k), 32'(Fault), 32'd0);
    end
    tick();
    check("tmo.fault", 32'(Fault), 32'd1);
    check("tmo.code", 32'(Fault_Code), 32'd1);
    check("tmo.mem_req", 32'(Mem_Req), 32'd0);
    check("tmo.busy", 32'(Busy), 32'd0);
    check("tmo.cycles", Cycle_Count, 32'd17);
    drive(7'b1000010);
    repeat (3) tick();
    check("tmo.frozen.strobe", 32'(Stage_Strobe), 32'd0);
    check("tmo.frozen.fault", 32'(Fault), 32'd1);
    check("tmo.frozen.cycles", Cycle_Count, 32'd17);
    check("tmo.frozen.instrs", Instr_Count, 32'd0);
    do_reset();
    check("tmo.recover.fault", 32'(Fault), 32'd0);
    check("tmo.recover.code", 32'(Fault_Code), 32'd0);

    // Bus error and MFC together: error wins, no strobe.
    drive(7'b1000000);
    tick();
    tick();
    check("err.mem_req", 32'(Mem_Req), 32'd1);
    drive(7'b1000011);
    #1;
    check("err.strobe", 32'(Stage_Strobe), 32'd0);
    tick();
    check("err.fault", 32'(Fault), 32'd1);
    check("err.code", 32'(Fault_Code), 32'd2);
    check("err.stage", 32'(Stage), 32'd1);

    // Reset asserted mid-wait clears Mem_Req before any clock edge.
    do_reset();
    drive(7'b1000000);
    tick();
    tick();
    check("arst.mem_req_before", 32'(Mem_Req), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst.mem_req", 32'(Mem_Req), 32'd0);
    check("arst.busy", 32'(Busy), 32'd0);
    check("arst.stage", 32'(Stage), 32'd1);
    tick();
    Reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised multi-cycle stage sequencer for the processor datapath.
- Replaces the free-running stage counter with a run/halt/single-step controller.
- Waits on the memory MFC handshake in fetch and memory stages, and detects memory timeouts and bus errors.
- Its per-stage strobes drive the IR/RA/RB/RZ/RM/RY/PC enables; its instruction/cycle counters feed the debug display.

Parameters:
- NUM_STAGES, 5, stages per instruction (>=2); stage numbering 1..NUM_STAGES.
- STAGE_W, 3, width of Stage output; must hold NUM_STAGES.
- MEM_STAGE, 4, stage index that performs a data memory access when Mem_Op=1.
- MEM_TIMEOUT, 16, max cycles waiting for MEM_MFC before fault (>=1).
- CNT_W, 32, width of Cycle_Count and Instr_Count.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  level; leaves IDLE and starts sequencing at stage 1.
- Halt_Req  in  1  level; stop at next instruction boundary.
- Mode_Step  in  1  1 = single-step mode (advance only on Step rising edge).
- Step  in  1  step request (already synchronised); internally edge-detected.
- Mem_Op  in  1  current instruction accesses memory in MEM_STAGE.
- MEM_MFC  in  1  memory function complete.
- MEM_ERROR  in  1  memory bus error.
- Stage  out  STAGE_W  current stage number, 1..NUM_STAGES.
- Stage_Strobe  out  NUM_STAGES  one-hot pulse; bit i = stage i+1 completes this cycle.
- Mem_Req  out  1  memory access outstanding.
- Busy  out  1  state is RUN or MEM_WAIT.
- Fault  out  1  sticky; sequencer in FAULT.
- Fault_Code  out  2  00 none, 01 timeout, 10 bus error.
- Cycle_Count  out  CNT_W  clocks spent in RUN/MEM_WAIT; wraps.
- Instr_Count  out  CNT_W  completed instructions; wraps.

Behaviour:
- Reset values (async on Reset_n=0):
  - state=IDLE, Stage=1, Stage_Strobe=0, Mem_Req=0, Busy=0, Fault=0, Fault_Code=00.
  - Both counters 0; timer 0; step edge register 0.
- Stage_Strobe and Mem_Req are registered-state decodes; no combinational path from MEM_MFC to Stage_Strobe except the advance term below.
- States: IDLE, RUN, MEM_WAIT, FAULT.
- IDLE:
  - Run=1 -> RUN, Stage=1.
  - Halt_Req=1 has priority over Run while in IDLE.
- go term: go = Mode_Step ? step_edge : 1. step_edge = Step & ~Step_d.
- RUN:
  - If Stage==1, or Stage==MEM_STAGE with Mem_Op=1, then on go enter MEM_WAIT, assert Mem_Req, clear timer.
  - Otherwise advance on go: Stage_Strobe[Stage-1]=1 for that cycle; Stage <= Stage+1.
- MEM_WAIT:
  - Mem_Req=1; timer increments each cycle.
  - MEM_ERROR=1 -> FAULT, code 10.
  - Else MEM_MFC=1 -> advance: strobe, Stage+1, back to RUN, Mem_Req drops next cycle.
  - Else timer==MEM_TIMEOUT-1 -> FAULT, code 01.
  - Step is ignored while waiting; the access completes without further Step.
- Advance out of Stage==NUM_STAGES:
  - Stage <= 1; Instr_Count += 1.
  - If Halt_Req=1 -> IDLE, else stay RUN.
- FAULT: all strobes 0, Mem_Req=0, counters frozen. Exit only via Reset_n.
- Cycle_Count increments every clock while Busy=1.
- Minimum latency (free-run, MFC returned in the same cycle as the request): fetch stage 2 clocks, other stages 1 clock.
- Simultaneous-event priority:
  - MEM_ERROR > MEM_MFC > timeout.
  - MFC in the timeout cycle counts as success.
  - Halt_Req mid-instruction has no effect until the boundary.
  - Run deasserted mid-instruction has no effect; only Halt_Req stops.
- Reset mid-MEM_WAIT: immediate IDLE, Mem_Req=0 asynchronously.
- Mode_Step toggled mid-instruction takes effect on the next go evaluation.

Decomposition:
- Package stage_seq_pkg:
  - state enum {IDLE, RUN, MEM_WAIT, FAULT}.
  - Fault_Code constants FC_NONE, FC_TIMEOUT, FC_BUSERR.
  - Helper function stage_onehot(stage, NUM_STAGES).
- Sub-module mem_wait_timer: clear/enable/expire counter, parametrised by MEM_TIMEOUT, with its own asynchronous active-low reset.

Test Plan:
- Free-run, Mem_Op=0, MFC held 1, Run=1 for 3 instructions:
  - Stage sequence 1,1,2,3,4,5 repeating.
  - Instr_Count=3 after 18 clocks; Cycle_Count=18; Stage_Strobe one-hot 00001..10000 in order.
- Mem_Op=1, MFC delayed 3 clocks in MEM_STAGE:
  - Stage holds at 4 with Mem_Req=1 for 4 clocks.
  - Strobe[3] pulses in the MFC cycle; instruction completes in 9 clocks.
- MFC never asserted at fetch, MEM_TIMEOUT=16:
  - Fault=1, Fault_Code=01 exactly 16 clocks after Mem_Req rises.
  - Counters frozen; only Reset_n recovers.
- MEM_ERROR and MEM_MFC both 1 in the same wait cycle -> Fault_Code=10, no strobe.
- Mode_Step=1, five Step pulses with MFC=1:
  - Stage 1 (wait), then 2, 3, 4, 5.
  - Level-held Step produces only one advance.
- Halt_Req raised in stage 2:
  - Sequencer finishes stage 5, Instr_Count+1, enters IDLE with Stage=1.
  - Reset_n pulse in MEM_WAIT clears Mem_Req without waiting for a Clock edge.
